// File: rtl/clint_access_master_pkg.sv
// rtl/clint_access_master_pkg.sv - shared constants, state type and decode helpers for the CLINT access master
package clint_access_master_pkg;

  localparam logic [63:0] MTIME_ADDR    = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] MTIMECMP_ADDR = 64'h0000_0000_0200_4000;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Offset must be a multiple of the access width in bytes.
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    case (size)
      SIZE_B:  is_misaligned = 1'b0;
      SIZE_H:  is_misaligned = off[0];
      SIZE_W:  is_misaligned = |off[1:0];
      default: is_misaligned = |off;
    endcase
  endfunction

  // Only the two timer double-words are reachable through this port.
  function automatic logic is_mapped(input logic [63:0] addr);
    is_mapped = (addr[63:3] == MTIME_ADDR[63:3]) || (addr[63:3] == MTIMECMP_ADDR[63:3]);
  endfunction

endpackage

// File: rtl/clint_lane_mux.sv
// rtl/clint_lane_mux.sv - byte-lane extraction/extension for loads and byte merge for sub-double-word stores
module clint_lane_mux
  import clint_access_master_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] load_o,
  output logic [63:0] merge_o
);

  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [63:0] size_mask;
  logic [63:0] lane_mask;

  assign shamt = {off_i, 3'b000};

  // Right-align the addressed lanes, extend them, and build the store merge over the old value.
  always_comb begin
    shifted   = rdata_i >> shamt;
    size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    load_o    = shifted;
    case (size_i)
      SIZE_B: begin
        size_mask = 64'h0000_0000_0000_00FF;
        load_o    = {{56{~unsigned_i & shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        size_mask = 64'h0000_0000_0000_FFFF;
        load_o    = {{48{~unsigned_i & shifted[15]}}, shifted[15:0]};
      end
      SIZE_W: begin
        size_mask = 64'h0000_0000_FFFF_FFFF;
        load_o    = {{32{~unsigned_i & shifted[31]}}, shifted[31:0]};
      end
      default: begin
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        load_o    = shifted;
      end
    endcase
    lane_mask = size_mask << shamt;
    merge_o   = (rdata_i & ~lane_mask) | ((wdata_i << shamt) & lane_mask);
  end

endmodule

// File: rtl/clint_access_master.sv
// rtl/clint_access_master.sv - load/store initiator for the timer register port with read-modify-write for narrow stores
module clint_access_master
  import clint_access_master_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [63:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [63:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        clint_cen_o,
  output logic        clint_wen_o,
  output logic [63:0] clint_addr_o,
  output logic [63:0] clint_wdata_o,
  input  logic [63:0] clint_rdata_i
);

  state_t      state_q, state_d;
  logic        wen_q, wen_d;
  logic [2:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] wdata_q, wdata_d;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        cen_q, cen_d;
  logic        cwen_q, cwen_d;
  logic [63:0] caddr_q, caddr_d;
  logic [63:0] cwdata_q, cwdata_d;

  logic [63:0] load_data;
  logic [63:0] merge_data;

  clint_lane_mux u_lane_mux (
    .rdata_i    (clint_rdata_i),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  // Next-state and next-output logic; every output is registered alongside the state.
  always_comb begin
    state_d     = state_q;
    wen_d       = wen_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cen_d       = 1'b0;
    cwen_d      = 1'b0;
    caddr_d     = 64'd0;
    cwdata_d    = 64'd0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          wen_d       = req_wen_i;
          off_d       = req_addr_i[2:0];
          size_d      = req_size_i;
          uns_d       = req_unsigned_i;
          wdata_d     = req_wdata_i;
          req_ready_d = 1'b0;
          if (is_misaligned(req_addr_i[2:0], req_size_i) || !is_mapped(req_addr_i)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 64'd0;
          end else if (req_wen_i && (req_size_i == SIZE_D)) begin
            state_d  = ST_WRITE;
            cen_d    = 1'b1;
            cwen_d   = 1'b1;
            caddr_d  = {req_addr_i[63:3], 3'b000};
            cwdata_d = req_wdata_i;
          end else begin
            state_d = ST_READ;
            cen_d   = 1'b1;
            caddr_d = {req_addr_i[63:3], 3'b000};
          end
        end
      end
      ST_READ: begin
        if (wen_q) begin
          state_d  = ST_WRITE;
          cen_d    = 1'b1;
          cwen_d   = 1'b1;
          caddr_d  = caddr_q;
          cwdata_d = merge_data;
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_data;
        end
      end
      ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 64'd0;
      end
      default: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 64'd0;
          req_ready_d = 1'b1;
        end
      end
    endcase
  end

  // State and registered outputs; reset drops the port strobes immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wen_q       <= 1'b0;
      off_q       <= 3'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      wdata_q     <= 64'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
      cen_q       <= 1'b0;
      cwen_q      <= 1'b0;
      caddr_q     <= 64'd0;
      cwdata_q    <= 64'd0;
    end else begin
      state_q     <= state_d;
      wen_q       <= wen_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cen_q       <= cen_d;
      cwen_q      <= cwen_d;
      caddr_q     <= caddr_d;
      cwdata_q    <= cwdata_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign clint_cen_o   = cen_q;
  assign clint_wen_o   = cwen_q;
  assign clint_addr_o  = caddr_q;
  assign clint_wdata_o = cwdata_q;

endmodule

// File: tb/tb_clint_access_master.sv
// tb/tb_clint_access_master.sv - directed and randomized checks of the CLINT access master against a byte-level model
module tb_clint_access_master;

  localparam logic [63:0] A_MTIME = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] A_CMP   = 64'h0000_0000_0200_4000;
  localparam logic [63:0] A_NONE  = 64'h0000_0000_0200_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_wen_i = 1'b0;
  logic [63:0] req_addr_i = 64'd0;
  logic [1:0]  req_size_i = 2'd0;
  logic        req_unsigned_i = 1'b0;
  logic [63:0] req_wdata_i = 64'd0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        clint_cen_o;
  logic        clint_wen_o;
  logic [63:0] clint_addr_o;
  logic [63:0] clint_wdata_o;
  logic [63:0] clint_rdata_i;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  clint_access_master dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_wen_i      (req_wen_i),
    .req_addr_i     (req_addr_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .clint_cen_o    (clint_cen_o),
    .clint_wen_o    (clint_wen_o),
    .clint_addr_o   (clint_addr_o),
    .clint_wdata_o  (clint_wdata_o),
    .clint_rdata_i  (clint_rdata_i)
  );

  // Timer slave: two registers, combinational read, write on the clock edge.
  logic [63:0] t_mtime = 64'd0;
  logic [63:0] t_cmp = 64'd0;
  logic        pl_en = 1'b0;
  logic        pl_sel = 1'b0;
  logic [63:0] pl_val = 64'd0;
  int          wr_count = 0;
  logic [63:0] last_wdata = 64'd0;

  assign clint_rdata_i = (clint_addr_o == A_MTIME) ? t_mtime :
                         (clint_addr_o == A_CMP)   ? t_cmp   : 64'd0;

  always @(posedge clk) begin
    if (pl_en) begin
      if (pl_sel) t_cmp <= pl_val;
      else        t_mtime <= pl_val;
    end else if (clint_cen_o && clint_wen_o) begin
      if (clint_addr_o == A_MTIME)    t_mtime <= clint_wdata_o;
      else if (clint_addr_o == A_CMP) t_cmp <= clint_wdata_o;
      wr_count   <= wr_count + 1;
      last_wdata <= clint_wdata_o;
    end
  end

  // Reference copies of the timer registers.
  logic [63:0] m_mtime = 64'd0;
  logic [63:0] m_cmp = 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input bit sel, input logic [63:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_sel = sel; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
    if (sel) m_cmp = val;
    else     m_mtime = val;
  endtask

  task automatic do_req(input bit wen, input logic [63:0] addr, input logic [1:0] size,
                        input bit uns, input logic [63:0] wdata, input int hold,
                        output logic [63:0] got);
    int n, off, hit, edges, ncen, nwr, wr0, exp_lat, exp_cen;
    bit err;
    logic [63:0] base, old, nv, val;
    logic [7:0] ob [8];
    logic [7:0] nb [8];
    n    = 1 << size;
    off  = int'(addr[2:0]);
    base = addr - 64'(off);
    hit  = (base == A_MTIME) ? 0 : (base == A_CMP) ? 1 : -1;
    err  = ((off % n) != 0) || (hit < 0);
    old  = (hit == 0) ? m_mtime : m_cmp;
    for (int i = 0; i < 8; i++) begin
      ob[i] = old[8*i +: 8];
      nb[i] = ob[i];
    end
    val = 64'd0;
    if (!err && !wen) begin
      for (int i = 0; i < n; i++) val = val | (64'(ob[off+i]) << (8*i));
      if (!uns && n < 8 && val[8*n-1]) val = val | (~64'd0 << (8*n));
    end
    if (!err && wen) for (int i = 0; i < n; i++) nb[off+i] = wdata[8*i +: 8];
    for (int i = 0; i < 8; i++) nv[8*i +: 8] = nb[i];
    exp_lat = err ? 1 : (wen && n < 8) ? 3 : 2;
    exp_cen = err ? 0 : (wen && n < 8) ? 2 : 1;

    @(negedge clk);
    req_valid_i = 1'b1; req_wen_i = wen; req_addr_i = addr;
    req_size_i = size; req_unsigned_i = uns; req_wdata_i = wdata;
    chk("req_ready_idle", 64'(req_ready_o), 64'd1);
    wr0 = wr_count;
    @(posedge clk);
    edges = 1; ncen = 0; nwr = 0;
    @(negedge clk);
    req_valid_i = 1'b0;
    while (!rsp_valid_o && edges < 8) begin
      if (clint_cen_o) begin
        ncen++;
        chk("clint_addr", clint_addr_o, base);
      end
      if (clint_cen_o && clint_wen_o) nwr++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("rsp_valid", 64'(rsp_valid_o), 64'd1);
    chk("latency", 64'(edges), 64'(exp_lat));
    chk("rsp_err", 64'(rsp_err_o), 64'(err));
    chk("rsp_rdata", rsp_rdata_o, val);
    chk("cen_cycles", 64'(ncen), 64'(exp_cen));
    chk("write_cycles", 64'(nwr), 64'((!err && wen) ? 1 : 0));
    chk("timer_writes", 64'(wr_count - wr0), 64'((!err && wen) ? 1 : 0));
    if (!err && wen) begin
      chk("write_data", last_wdata, nv);
      if (hit == 0) m_mtime = nv;
      else          m_cmp = nv;
    end
    chk("mtime_reg", t_mtime, m_mtime);
    chk("mtimecmp_reg", t_cmp, m_cmp);
    got = rsp_rdata_o;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid_o), 64'd1);
      chk("hold_rdata", rsp_rdata_o, val);
      chk("hold_err", 64'(rsp_err_o), 64'(err));
      chk("hold_ready", 64'(req_ready_o), 64'd0);
      chk("hold_cen", 64'(clint_cen_o), 64'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("post_valid", 64'(rsp_valid_o), 64'd0);
    chk("post_ready", 64'(req_ready_o), 64'd1);
    chk("post_cen", 64'(clint_cen_o), 64'd0);
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] base_sel;
    rst = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata_o, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err_o), 64'd0);
    chk("rst_cen", 64'(clint_cen_o), 64'd0);
    chk("rst_wen", 64'(clint_wen_o), 64'd0);
    chk("rst_addr", clint_addr_o, 64'd0);
    chk("rst_wdata", clint_wdata_o, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    preload(1'b0, 64'h1234);
    preload(1'b1, 64'd0);
    do_req(1'b0, A_MTIME, 2'd3, 1'b0, 64'd0, 0, got);
    chk("dir_mtime_load", got, 64'h1234);

    do_req(1'b1, A_CMP, 2'd3, 1'b0, 64'h10, 0, got);
    do_req(1'b0, A_CMP, 2'd3, 1'b0, 64'd0, 0, got);
    chk("dir_cmp_readback", got, 64'h10);

    preload(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    do_req(1'b1, A_CMP + 64'd3, 2'd0, 1'b0, 64'hAB, 0, got);
    chk("dir_byte_merge", last_wdata, 64'hFFFF_FFFF_ABFF_FFFF);

    preload(1'b1, 64'h8000_0001_0000_0000);
    do_req(1'b0, A_CMP + 64'd4, 2'd2, 1'b0, 64'd0, 0, got);
    chk("dir_word_signed", got, 64'hFFFF_FFFF_8000_0001);
    do_req(1'b0, A_CMP + 64'd4, 2'd2, 1'b1, 64'd0, 0, got);
    chk("dir_word_unsigned", got, 64'h0000_0000_8000_0001);

    do_req(1'b0, A_CMP + 64'd1, 2'd1, 1'b0, 64'd0, 0, got);
    do_req(1'b0, A_NONE, 2'd3, 1'b0, 64'd0, 0, got);
    do_req(1'b1, A_NONE + 64'd2, 2'd1, 1'b0, 64'hBEEF, 0, got);

    do_req(1'b0, A_MTIME, 2'd3, 1'b0, 64'd0, 5, got);

    // Reset while the narrow store sits in its WRITE cycle.
    preload(1'b1, 64'h1111_2222_3333_4444);
    @(negedge clk);
    req_valid_i = 1'b1; req_wen_i = 1'b1; req_addr_i = A_CMP;
    req_size_i = 2'd0; req_unsigned_i = 1'b0; req_wdata_i = 64'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_write_phase", 64'({clint_cen_o, clint_wen_o}), 64'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_cen", 64'(clint_cen_o), 64'd0);
    chk("mid_rst_wen", 64'(clint_wen_o), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_cmp_kept", t_cmp, 64'h1111_2222_3333_4444);
    rst = 1'b0;
    do_req(1'b0, A_CMP, 2'd3, 1'b0, 64'd0, 0, got);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) preload(1'($urandom_range(0, 1)), {$urandom, $urandom});
      case ($urandom_range(0, 3))
        0:       base_sel = A_MTIME;
        2:       base_sel = A_NONE;
        default: base_sel = A_CMP;
      endcase
      do_req(1'($urandom_range(0, 1)), base_sel + 64'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, $urandom_range(0, 2), got);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
